wta_disparity_select: RTL and testbench

- Winner-take-all stage directly downstream of the census Hamming-distance stage.
- Accepts one matching cost per cycle, streamed disparity 0..MAX_DISP-1 for each pixel in order.
- Tracks the minimum and second-minimum cost, then emits one disparity per pixel with a uniqueness/confidence flag.
- Output feeds the depth-map writer through a valid/ready handshake.

---
 rtl/wta_disparity_select.sv | 144 ++++++++++++++
 tb/tb_wta_disparity_select.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wta_disparity_select.sv
`default_nettype none
// ============================================================================
// wta_disparity_select
// Winner-take-all disparity selection with min/second-min uniqueness check.
// Rev 1.0
// ============================================================================
module wta_disparity_select #(
  parameter int COST_WIDTH  = 4,
  parameter int MAX_DISP    = 64,
  parameter int DISP_WIDTH  = $clog2(MAX_DISP),
  parameter int UNIQ_MARGIN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COST_WIDTH-1:0] cost_in,
  input  logic                  cost_first,
  input  logic                  cost_valid,
  output logic                  cost_ready,
  output logic [DISP_WIDTH-1:0] disp_out,
  output logic [COST_WIDTH-1:0] min_cost,
  output logic                  disp_unique,
  output logic                  disp_valid,
  input  logic                  disp_ready,
  output logic                  sync_err
);

  localparam logic [DISP_WIDTH-1:0] LAST_IDX = DISP_WIDTH'(MAX_DISP - 1);
  localparam logic [COST_WIDTH:0]   MARGIN   = (COST_WIDTH + 1)'(UNIQ_MARGIN);
  localparam logic [COST_WIDTH-1:0] COST_MAX = '1;

  // Running per-pixel state
  logic [DISP_WIDTH-1:0] d_cnt_q,       d_cnt_d;
  logic [COST_WIDTH-1:0] best_q,        best_d;
  logic [DISP_WIDTH-1:0] best_idx_q,    best_idx_d;
  logic [COST_WIDTH-1:0] second_q,      second_d;

  // Output registers
  logic [DISP_WIDTH-1:0] disp_out_q,    disp_out_d;
  logic [COST_WIDTH-1:0] min_cost_q,    min_cost_d;
  logic                  disp_unique_q, disp_unique_d;
  logic                  disp_valid_q,  disp_valid_d;
  logic                  sync_err_q,    sync_err_d;

  logic                  accept;
  logic                  at_zero;
  logic                  restart;
  logic [DISP_WIDTH-1:0] eff_idx;
  logic                  is_last;
  logic [COST_WIDTH-1:0] upd_best;
  logic [DISP_WIDTH-1:0] upd_best_idx;
  logic [COST_WIDTH-1:0] upd_second;
  logic [COST_WIDTH:0]   upd_gap;

  always_comb begin
    cost_ready = !disp_valid_q || disp_ready;
    accept     = cost_valid && cost_ready;
    at_zero    = (d_cnt_q == '0);
    // A first marker or an empty counter both start a fresh pixel at index 0.
    restart    = cost_first || at_zero;
    eff_idx    = restart ? '0 : d_cnt_q;
    is_last    = (eff_idx == LAST_IDX);
  end

  always_comb begin
    upd_best     = best_q;
    upd_best_idx = best_idx_q;
    upd_second   = second_q;
    if (restart) begin
      upd_best     = cost_in;
      upd_best_idx = '0;
      upd_second   = COST_MAX;
    end else if (cost_in < best_q) begin
      upd_second   = best_q;
      upd_best     = cost_in;
      upd_best_idx = eff_idx;
    end else if (cost_in < second_q) begin
      upd_second   = cost_in;
    end
    upd_gap = {1'b0, upd_second} - {1'b0, upd_best};
  end

  always_comb begin
    d_cnt_d       = d_cnt_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    second_d      = second_q;
    disp_out_d    = disp_out_q;
    min_cost_d    = min_cost_q;
    disp_unique_d = disp_unique_q;
    disp_valid_d  = disp_valid_q;
    sync_err_d    = 1'b0;

    if (disp_valid_q && disp_ready) begin
      disp_valid_d = 1'b0;
    end

    if (accept) begin
      sync_err_d = cost_first ^ at_zero;
      best_d     = upd_best;
      best_idx_d = upd_best_idx;
      second_d   = upd_second;
      d_cnt_d    = is_last ? '0 : eff_idx + 1'b1;
      // Last beat publishes; overrides a same-cycle downstream accept.
      if (is_last) begin
        disp_out_d    = upd_best_idx;
        min_cost_d    = upd_best;
        disp_unique_d = (upd_gap >= MARGIN);
        disp_valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_cnt_q       <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      second_q      <= COST_MAX;
      disp_out_q    <= '0;
      min_cost_q    <= '0;
      disp_unique_q <= 1'b0;
      disp_valid_q  <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      d_cnt_q       <= d_cnt_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      second_q      <= second_d;
      disp_out_q    <= disp_out_d;
      min_cost_q    <= min_cost_d;
      disp_unique_q <= disp_unique_d;
      disp_valid_q  <= disp_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign disp_out    = disp_out_q;
  assign min_cost    = min_cost_q;
  assign disp_unique = disp_unique_q;
  assign disp_valid  = disp_valid_q;
  assign sync_err    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wta_disparity_select.sv
`default_nettype none
// ============================================================================
// tb_wta_disparity_select
// Directed and randomized bench for wta_disparity_select (MAX_DISP=8).
// Rev 1.0
// ============================================================================
module tb_wta_disparity_select;

  localparam int CW   = 4;
  localparam int MD   = 8;
  localparam int DW   = 3;
  localparam int UM   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cost_in;
  logic          cost_first;
  logic          cost_valid;
  logic          cost_ready;
  logic [DW-1:0] disp_out;
  logic [CW-1:0] min_cost;
  logic          disp_unique;
  logic          disp_valid;
  logic          disp_ready;
  logic          sync_err;

  wta_disparity_select #(
    .COST_WIDTH (CW),
    .MAX_DISP   (MD),
    .DISP_WIDTH (DW),
    .UNIQ_MARGIN(UM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cost_in    (cost_in),
    .cost_first (cost_first),
    .cost_valid (cost_valid),
    .cost_ready (cost_ready),
    .disp_out   (disp_out),
    .min_cost   (min_cost),
    .disp_unique(disp_unique),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the pixel's costs so far, and the published result.
  int q_costs[$];
  bit m_valid  = 1'b0;
  int m_disp   = 0;
  int m_min    = 0;
  int m_uniq   = 0;
  int m_sync   = 0;
  int stall    = 0;
  int retries  = 0;
  int n_results = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Winner = smallest cost, lowest index on ties; runner-up = second entry of sorted list.
  task automatic judge_pixel();
    int s[$];
    s = q_costs;
    s.sort();
    m_min  = s[0];
    m_uniq = ((s[1] - s[0]) >= UM) ? 1 : 0;
    m_disp = 0;
    for (int i = MD - 1; i >= 0; i--)
      if (q_costs[i] == m_min) m_disp = i;
  endtask

  task automatic do_cycle(input bit v, input bit f, input int c, output bit acc);
    bit r;
    bit done;
    r = (stall == 0);
    if (stall > 0) stall--;
    cost_valid = v;
    cost_first = f;
    cost_in    = CW'(c);
    disp_ready = r;
    #1;
    chk("cost_ready", int'(cost_ready), int'(!m_valid || r));
    acc    = v && (!m_valid || r);
    done   = 1'b0;
    m_sync = 0;
    if (acc) begin
      if (f || q_costs.size() == 0) begin
        m_sync = (f != (q_costs.size() == 0)) ? 1 : 0;
        q_costs.delete();
      end
      q_costs.push_back(c);
      if (q_costs.size() == MD) begin
        judge_pixel();
        q_costs.delete();
        m_valid = 1'b1;
        done    = 1'b1;
        n_results++;
      end
    end
    if (!done && m_valid && r) m_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sync_err", int'(sync_err), m_sync);
    chk("disp_valid", int'(disp_valid), int'(m_valid));
    if (m_valid) begin
      chk("disp_out", int'(disp_out), m_disp);
      chk("min_cost", int'(min_cost), m_min);
      chk("disp_unique", int'(disp_unique), m_uniq);
    end
    cost_valid = 1'b0;
    cost_first = 1'b0;
  endtask

  task automatic send(input bit f, input int c);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      do_cycle(1'b1, f, c, acc);
      if (!acc) retries++;
    end
    if (!acc) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 0, acc);
  endtask

  task automatic send_pixel(input int c[MD]);
    for (int i = 0; i < MD; i++) send(i == 0, c[i]);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    cost_valid = 1'b1;
    cost_first = 1'b0;
    cost_in    = 4'd1;
    disp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_disp_out", int'(disp_out), 0);
    chk("rst_min_cost", int'(min_cost), 0);
    chk("rst_disp_unique", int'(disp_unique), 0);
    chk("rst_disp_valid", int'(disp_valid), 0);
    chk("rst_sync_err", int'(sync_err), 0);
    rst        = 1'b0;
    cost_valid = 1'b0;
    q_costs.delete();
    m_valid    = 1'b0;
    stall      = 0;
  endtask

  initial begin
    int pa[MD] = '{7, 6, 5, 2, 5, 6, 7, 8};
    int pb[MD] = '{4, 1, 3, 1, 5, 5, 5, 5};
    int pc[MD] = '{3, 3, 3, 3, 3, 3, 3, 3};
    int rp[MD];
    int base;

    rst = 1'b1; cost_in = '0; cost_first = 1'b0; cost_valid = 1'b0; disp_ready = 1'b1;
    @(posedge clk);
    do_reset();

    // Clean pixel: winner at index 3, unique.
    send_pixel(pa);
    chk("pa_disp_out", int'(disp_out), 3);
    chk("pa_min_cost", int'(min_cost), 2);
    chk("pa_unique", int'(disp_unique), 1);
    idle(2);

    // Tied minimum: lower index wins, not unique.
    send_pixel(pb);
    chk("pb_disp_out", int'(disp_out), 1);
    chk("pb_unique", int'(disp_unique), 0);
    idle(1);

    // Back-to-back pixels with 5-cycle downstream stall after the first result.
    send_pixel(pa);
    stall = 5;
    send_pixel(pb);
    idle(2);

    // Re-sync: cost_first on the 4th beat restarts the pixel.
    for (int i = 0; i < 3; i++) send(i == 0, 8 - i);
    send(1'b1, 6);
    for (int i = 1; i < MD; i++) send(1'b0, (i * 5) % 9);
    idle(1);

    // Missing cost_first at a pixel boundary.
    for (int i = 0; i < MD; i++) send(1'b0, 8 - i);
    idle(1);

    // Reset mid-pixel, then a clean pixel.
    for (int i = 0; i < 3; i++) send(i == 0, 0);
    do_reset();
    send_pixel(pa);
    idle(1);

    // 16 equal-cost pixels at full rate.
    retries = 0;
    base    = n_results;
    for (int p = 0; p < 16; p++) send_pixel(pc);
    chk("stream_bubbles", retries, 0);
    chk("stream_results", n_results - base, 16);
    idle(1);

    // Randomized costs, backpressure and occasional sync faults.
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < MD; i++) rp[i] = int'($urandom_range(0, 8));
      for (int i = 0; i < MD; i++) begin
        if ($urandom_range(0, 9) < 3) stall = int'($urandom_range(1, 3));
        send((i == 0) ^ ($urandom_range(0, 19) == 0), rp[i]);
      end
    end
    stall = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
